// File: rtl/arbitro_rr.sv
// arbitro_rr: merges four per-class FIFOs into one output FIFO.
// Each cycle one eligible class FIFO is popped, and its word is pushed to the
// output FIFO on the following cycle. Class selection is round-robin by default.
// Build option: define ARB_STRICT_PRIO_EN for fixed priority (class 0 highest,
// class 3 lowest). In that build there is no round-robin pointer.
//
// Handshake: pop[i] is a one-cycle read strobe, and class FIFO i accepts it
// unconditionally. Its read data appears on data_in the next cycle. push is a
// one-cycle write strobe that the output FIFO also accepts unconditionally.
// The only backpressure is almost_full, sampled at each rising edge. The
// output FIFO threshold must leave 2 free entries for the pop and push that
// may already be in flight.
module arbitro_rr #(
    parameter int WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           empty,
    input  logic [4*WIDTH-1:0]   data_in,
    input  logic                 almost_full,
    output logic [3:0]           pop,
    output logic                 push,
    output logic [WIDTH-1:0]     data_out,
    output logic [1:0]           grant_id,
    output logic [0:0]           dbg_state,
    output logic [1:0]           dbg_rr_ptr
);

    // The FSM mirrors pop: IDLE while pop is zero, GRANT while a pop is issued.
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [3:0] pop_q, pop_d;
    logic       push_q, push_d;
    logic [1:0] grant_id_q, grant_id_d;
    logic [0:0] state_q, state_d;
    logic [3:0] eligible;
    logic       grant_en;
    logic [1:0] gnt_idx;

    // A pop still in flight has not yet reached empty. Excluding that class
    // prevents a double pop of a FIFO that holds a single entry.
    assign eligible = ~empty & ~pop_q;
    assign grant_en = ~almost_full & (|eligible);

`ifdef ARB_STRICT_PRIO_EN
    // Fixed priority: the lowest-numbered eligible class wins.
    always_comb begin
        gnt_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (eligible[k]) begin
                gnt_idx = 2'(k);
            end
        end
    end

    assign dbg_rr_ptr = 2'd0;
`else
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [1:0] cand;
    logic       found;

    // Round-robin: first eligible class, searching upward (mod 4) from rr_ptr.
    always_comb begin
        gnt_idx = rr_ptr_q;
        cand    = rr_ptr_q;
        found   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr_q + 2'(k);
            if (!found && eligible[cand]) begin
                gnt_idx = cand;
                found   = 1'b1;
            end
        end
    end

    // Pointer moves past the granted class; holds while stalled or idle.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_en) begin
            rr_ptr_d = gnt_idx + 2'd1;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= 2'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign dbg_rr_ptr = rr_ptr_q;
`endif

    // Next pop, push stage, and FSM state.
    always_comb begin
        pop_d      = 4'b0000;
        state_d    = IDLE;
        push_d     = |pop_q;
        grant_id_d = 2'd0;
        if (grant_en) begin
            pop_d   = 4'b0001 << gnt_idx;
            state_d = GRANT;
        end
        case (pop_q)
            4'b0010: grant_id_d = 2'd1;
            4'b0100: grant_id_d = 2'd2;
            4'b1000: grant_id_d = 2'd3;
            default: grant_id_d = 2'd0;
        endcase
    end

    // Pop stage and push stage registers. Reset drops any pending push.
    always_ff @(posedge clk) begin
        if (reset) begin
            pop_q      <= 4'b0000;
            push_q     <= 1'b0;
            grant_id_q <= 2'd0;
            state_q    <= IDLE;
        end else begin
            pop_q      <= pop_d;
            push_q     <= push_d;
            grant_id_q <= grant_id_d;
            state_q    <= state_d;
        end
    end

    // Output word: read data of the class being pushed.
    always_comb begin
        data_out = data_in[WIDTH-1:0];
        case (grant_id_q)
            2'd0: data_out = data_in[0*WIDTH +: WIDTH];
            2'd1: data_out = data_in[1*WIDTH +: WIDTH];
            2'd2: data_out = data_in[2*WIDTH +: WIDTH];
            2'd3: data_out = data_in[3*WIDTH +: WIDTH];
            default: data_out = data_in[WIDTH-1:0];
        endcase
    end

    assign pop       = pop_q;
    assign push      = push_q;
    assign grant_id  = grant_id_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_arbitro_rr.sv
// tb_arbitro_rr: self-checking bench for arbitro_rr.
// The four class FIFOs are modelled in the bench: a pop strobe seen at an edge
// moves the head word onto data_in and refreshes empty just after that edge.
module tb_arbitro_rr;
    localparam int W = 10;

    // Clock and reset
    logic           clk = 1'b0;
    logic           reset;
    logic [3:0]     empty;
    logic [4*W-1:0] data_in;
    logic           almost_full;
    logic [3:0]     pop;
    logic           push;
    logic [W-1:0]   data_out;
    logic [1:0]     grant_id;
    logic [0:0]     dbg_state;
    logic [1:0]     dbg_rr_ptr;

    always #5 clk = ~clk;

    arbitro_rr #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .empty       (empty),
        .data_in     (data_in),
        .almost_full (almost_full),
        .pop         (pop),
        .push        (push),
        .data_out    (data_out),
        .grant_id    (grant_id),
        .dbg_state   (dbg_state),
        .dbg_rr_ptr  (dbg_rr_ptr)
    );

    // Counters and scoreboard
    int n_cmp  = 0;
    int n_fail = 0;
    int n_underflow = 0;

    logic [W+1:0] exp_q[$];
    logic [W+1:0] obs_q[$];
    logic [3:0]   pop_hist[$];
    logic         push_hist[$];
    logic [1:0]   gid_hist[$];
    logic [1:0]   ptr_hist[$];
    logic [0:0]   st_hist[$];
    logic [3:0]   smp_pop;

    // Class FIFO contents
    logic [W-1:0] fq0[$];
    logic [W-1:0] fq1[$];
    logic [W-1:0] fq2[$];
    logic [W-1:0] fq3[$];

    function automatic logic [W-1:0] word_of(int c, int k);
        return W'(c * 64 + k * 5 + 3);
    endfunction

    function automatic int fifo_size(int i);
        case (i)
            0: return fq0.size();
            1: return fq1.size();
            2: return fq2.size();
            3: return fq3.size();
            default: return 0;
        endcase
    endfunction

    task automatic refresh_empty();
        for (int i = 0; i < 4; i++) begin
            empty[i] = (fifo_size(i) == 0);
        end
    endtask

    task automatic fifo_load(int c, logic [W-1:0] w);
        case (c)
            0: fq0.push_back(w);
            1: fq1.push_back(w);
            2: fq2.push_back(w);
            default: fq3.push_back(w);
        endcase
    endtask

    task automatic fifo_pop(int c);
        logic [W-1:0] w;
        if (fifo_size(c) == 0) begin
            n_underflow++;
        end else begin
            case (c)
                0: w = fq0.pop_front();
                1: w = fq1.pop_front();
                2: w = fq2.pop_front();
                default: w = fq3.pop_front();
            endcase
            data_in[c*W +: W] = w;
        end
    endtask

    task automatic fifo_flush();
        fq0.delete();
        fq1.delete();
        fq2.delete();
        fq3.delete();
        refresh_empty();
    endtask

    task automatic clear_logs();
        exp_q.delete();
        obs_q.delete();
        pop_hist.delete();
        push_hist.delete();
        gid_hist.delete();
        ptr_hist.delete();
        st_hist.delete();
    endtask

    // Driver: sample outputs mid-cycle on the falling edge.
    task automatic sample_neg();
        @(negedge clk);
        smp_pop = pop;
        pop_hist.push_back(pop);
        push_hist.push_back(push);
        gid_hist.push_back(grant_id);
        ptr_hist.push_back(dbg_rr_ptr);
        st_hist.push_back(dbg_state);
        if (push) begin
            obs_q.push_back({grant_id, data_out});
        end
    endtask

    // Driver: let the FIFO models act on the pop seen at the rising edge.
    task automatic advance_pos();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (smp_pop[i]) fifo_pop(i);
        end
        refresh_empty();
    endtask

    task automatic cycle();
        sample_neg();
        advance_pos();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        almost_full = 1'b0;
        data_in = '0;
        fifo_flush();
        smp_pop = 4'b0000;
        repeat (3) cycle();
        reset = 1'b0;
        clear_logs();
        sample_neg();
        n_cmp++;
        if (pop_hist[0] !== 4'b0000) begin n_fail++; $display("FAIL reset_pop: got %b want 0000", pop_hist[0]); end
        n_cmp++;
        if (push_hist[0] !== 1'b0) begin n_fail++; $display("FAIL reset_push: got %b want 0", push_hist[0]); end
        n_cmp++;
        if (gid_hist[0] !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d want 0", gid_hist[0]); end
        n_cmp++;
        if (ptr_hist[0] !== 2'd0) begin n_fail++; $display("FAIL reset_rr_ptr: got %0d want 0", ptr_hist[0]); end
        advance_pos();
        clear_logs();
        repeat (10) cycle();
        for (int j = 0; j < 10; j++) begin
            n_cmp++;
            if (pop_hist[j] !== 4'b0000) begin n_fail++; $display("FAIL idle_pop[%0d]: got %b want 0000", j, pop_hist[j]); end
            n_cmp++;
            if (push_hist[j] !== 1'b0) begin n_fail++; $display("FAIL idle_push[%0d]: got %b want 0", j, push_hist[j]); end
        end
    endtask

    task automatic test_round_robin();
        int f;
        clear_logs();
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 4; c++) begin
                fifo_load(c, word_of(c, k));
                exp_q.push_back({2'(c), word_of(c, k)});
            end
        end
        refresh_empty();
        repeat (20) cycle();
        f = -1;
        for (int j = 0; j < pop_hist.size(); j++) begin
            if (f < 0 && pop_hist[j] != 4'b0000) f = j;
        end
        n_cmp++;
        if (f < 0 || f + 13 >= pop_hist.size()) begin
            n_fail++;
            $display("FAIL rr_first_pop: got index %0d want a pop within the window", f);
        end else begin
            for (int j = 0; j < 12; j++) begin
                logic [3:0] ep;
                ep = 4'b0001 << (j % 4);
                n_cmp++;
                if (pop_hist[f+j] !== ep) begin n_fail++; $display("FAIL rr_pop[%0d]: got %b want %b", j, pop_hist[f+j], ep); end
                n_cmp++;
                if (push_hist[f+1+j] !== 1'b1) begin n_fail++; $display("FAIL rr_push[%0d]: got %b want 1", j, push_hist[f+1+j]); end
                n_cmp++;
                if (gid_hist[f+1+j] !== 2'(j % 4)) begin n_fail++; $display("FAIL rr_grant_id[%0d]: got %0d want %0d", j, gid_hist[f+1+j], j % 4); end
            end
            n_cmp++;
            if (pop_hist[f+12] !== 4'b0000) begin n_fail++; $display("FAIL rr_pop_after: got %b want 0000", pop_hist[f+12]); end
        end
        n_cmp++;
        if (obs_q.size() !== 12) begin n_fail++; $display("FAIL rr_push_count: got %0d want 12", obs_q.size()); end
        for (int j = 0; j < 12 && j < obs_q.size(); j++) begin
            n_cmp++;
            if (obs_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL rr_word[%0d]: got %h want %h", j, obs_q[j], exp_q[j]); end
        end
        // Last grant was class 3 with the pointer at 3: pointer wraps to 0.
        n_cmp++;
        if (dbg_rr_ptr !== 2'd0) begin n_fail++; $display("FAIL rr_ptr_wrap: got %0d want 0", dbg_rr_ptr); end
        n_cmp++;
        if (n_underflow !== 0) begin n_fail++; $display("FAIL rr_double_pop: got %0d want 0", n_underflow); end
    endtask

    task automatic test_single();
        int np;
        logic [3:0] pv;
        clear_logs();
        fifo_load(2, word_of(2, 7));
        exp_q.push_back({2'd2, word_of(2, 7)});
        refresh_empty();
        repeat (8) cycle();
        np = 0;
        pv = 4'b0000;
        foreach (pop_hist[j]) begin
            if (pop_hist[j] != 4'b0000) begin np++; pv = pop_hist[j]; end
        end
        n_cmp++;
        if (np !== 1) begin n_fail++; $display("FAIL single_pop_count: got %0d want 1", np); end
        n_cmp++;
        if (pv !== 4'b0100) begin n_fail++; $display("FAIL single_pop_value: got %b want 0100", pv); end
        n_cmp++;
        if (obs_q.size() !== 1) begin n_fail++; $display("FAIL single_push_count: got %0d want 1", obs_q.size()); end
        else begin
            n_cmp++;
            if (obs_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL single_word: got %h want %h", obs_q[0], exp_q[0]); end
        end
        n_cmp++;
        if (n_underflow !== 0) begin n_fail++; $display("FAIL single_double_pop: got %0d want 0", n_underflow); end
    endtask

    task automatic test_almost_full();
        int k2, np, af_cnt, ni;
        logic [3:0] nz[$];
        clear_logs();
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 2; c++) begin
                fifo_load(c, word_of(c, k));
                exp_q.push_back({2'(c), word_of(c, k)});
            end
        end
        refresh_empty();
        k2 = -1;
        np = 0;
        af_cnt = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            sample_neg();
            if (smp_pop != 4'b0000) np++;
            if (k2 < 0 && np == 2) begin
                k2 = pop_hist.size() - 1;
                almost_full = 1'b1;
            end else if (almost_full) begin
                af_cnt++;
                if (af_cnt == 4) almost_full = 1'b0;
            end
            advance_pos();
        end
        almost_full = 1'b0;
        n_cmp++;
        if (k2 < 0) begin
            n_fail++;
            $display("FAIL af_second_pop: got none want a second pop");
        end else begin
            for (int j = 1; j <= 4; j++) begin
                n_cmp++;
                if (pop_hist[k2+j] !== 4'b0000) begin n_fail++; $display("FAIL af_pop_stall[%0d]: got %b want 0000", j, pop_hist[k2+j]); end
            end
            n_cmp++;
            if (push_hist[k2+1] !== 1'b1) begin n_fail++; $display("FAIL af_inflight_push: got %b want 1", push_hist[k2+1]); end
            n_cmp++;
            if (gid_hist[k2+1] !== 2'd1) begin n_fail++; $display("FAIL af_inflight_gid: got %0d want 1", gid_hist[k2+1]); end
            for (int j = 2; j <= 4; j++) begin
                n_cmp++;
                if (push_hist[k2+j] !== 1'b0) begin n_fail++; $display("FAIL af_push_stall[%0d]: got %b want 0", j, push_hist[k2+j]); end
            end
            n_cmp++;
            if (st_hist[k2+2] !== 1'b0) begin n_fail++; $display("FAIL af_state_idle: got %b want 0", st_hist[k2+2]); end
`ifndef ARB_STRICT_PRIO_EN
            n_cmp++;
            if (ptr_hist[k2+3] !== 2'd2) begin n_fail++; $display("FAIL af_ptr_hold: got %0d want 2", ptr_hist[k2+3]); end
`endif
            n_cmp++;
            if (pop_hist[k2+5] !== 4'b0001) begin n_fail++; $display("FAIL af_resume_pop: got %b want 0001", pop_hist[k2+5]); end
        end
        foreach (pop_hist[j]) begin
            if (pop_hist[j] != 4'b0000) nz.push_back(pop_hist[j]);
        end
        n_cmp++;
        if (nz.size() !== 6) begin n_fail++; $display("FAIL af_pop_count: got %0d want 6", nz.size()); end
        ni = (nz.size() < 6) ? nz.size() : 6;
        for (int j = 0; j < ni; j++) begin
            logic [3:0] ep;
            ep = (j % 2 == 0) ? 4'b0001 : 4'b0010;
            n_cmp++;
            if (nz[j] !== ep) begin n_fail++; $display("FAIL af_pop_seq[%0d]: got %b want %b", j, nz[j], ep); end
        end
        n_cmp++;
        if (obs_q.size() !== 6) begin n_fail++; $display("FAIL af_push_count: got %0d want 6", obs_q.size()); end
        for (int j = 0; j < 6 && j < obs_q.size(); j++) begin
            n_cmp++;
            if (obs_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL af_word[%0d]: got %h want %h", j, obs_q[j], exp_q[j]); end
        end
        n_cmp++;
        if (n_underflow !== 0) begin n_fail++; $display("FAIL af_double_pop: got %0d want 0", n_underflow); end
    endtask

    task automatic test_reset_mid();
        int kr;
        clear_logs();
        for (int k = 0; k < 2; k++) begin
            fifo_load(0, word_of(0, k + 10));
            fifo_load(1, word_of(1, k + 10));
        end
        // Only the class-0 word completes; the class-1 word popped as reset hits is lost.
        exp_q.push_back({2'd0, word_of(0, 10)});
        refresh_empty();
        kr = -1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            sample_neg();
            if (kr < 0 && smp_pop == 4'b0010) begin
                reset = 1'b1;
                kr = pop_hist.size() - 1;
            end else if (reset) begin
                fifo_flush();
                smp_pop = 4'b0000;
                reset = 1'b0;
            end
            advance_pos();
        end
        reset = 1'b0;
        n_cmp++;
        if (kr < 0) begin
            n_fail++;
            $display("FAIL rst_mid_pop: got no 0010 pop want one");
        end else begin
            n_cmp++;
            if (push_hist[kr] !== 1'b1) begin n_fail++; $display("FAIL rst_mid_prior_push: got %b want 1", push_hist[kr]); end
            n_cmp++;
            if (push_hist[kr+1] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_push: got %b want 0", push_hist[kr+1]); end
            n_cmp++;
            if (gid_hist[kr+1] !== 2'd0) begin n_fail++; $display("FAIL rst_mid_gid: got %0d want 0", gid_hist[kr+1]); end
            n_cmp++;
            if (ptr_hist[kr+1] !== 2'd0) begin n_fail++; $display("FAIL rst_mid_ptr: got %0d want 0", ptr_hist[kr+1]); end
            n_cmp++;
            if (pop_hist[kr+1] !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_pop_clear: got %b want 0000", pop_hist[kr+1]); end
        end
        n_cmp++;
        if (obs_q.size() !== 1) begin n_fail++; $display("FAIL rst_mid_push_count: got %0d want 1", obs_q.size()); end
        else begin
            n_cmp++;
            if (obs_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL rst_mid_word: got %h want %h", obs_q[0], exp_q[0]); end
        end
    endtask

`ifdef ARB_STRICT_PRIO_EN
    task automatic test_strict();
        logic [3:0] nz[$];
        clear_logs();
        for (int k = 0; k < 2; k++) begin
            fifo_load(0, word_of(0, k + 20));
            exp_q.push_back({2'd0, word_of(0, k + 20)});
            fifo_load(3, word_of(3, k + 20));
            exp_q.push_back({2'd3, word_of(3, k + 20)});
        end
        refresh_empty();
        repeat (12) cycle();
        foreach (pop_hist[j]) begin
            if (pop_hist[j] != 4'b0000) nz.push_back(pop_hist[j]);
        end
        n_cmp++;
        if (nz.size() !== 4) begin n_fail++; $display("FAIL strict_pop_count: got %0d want 4", nz.size()); end
        for (int j = 0; j < 4 && j < nz.size(); j++) begin
            logic [3:0] ep;
            ep = (j % 2 == 0) ? 4'b0001 : 4'b1000;
            n_cmp++;
            if (nz[j] !== ep) begin n_fail++; $display("FAIL strict_pop_seq[%0d]: got %b want %b", j, nz[j], ep); end
        end
        n_cmp++;
        if (obs_q.size() !== 4) begin n_fail++; $display("FAIL strict_push_count: got %0d want 4", obs_q.size()); end
        for (int j = 0; j < 4 && j < obs_q.size(); j++) begin
            n_cmp++;
            if (obs_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL strict_word[%0d]: got %h want %h", j, obs_q[j], exp_q[j]); end
        end
    endtask
`endif

    // Sequence of scenarios and final report
    initial begin
        reset = 1'b1;
        empty = 4'hF;
        data_in = '0;
        almost_full = 1'b0;
        smp_pop = 4'b0000;
        test_reset();
`ifndef ARB_STRICT_PRIO_EN
        test_round_robin();
`endif
        test_single();
        test_almost_full();
        test_reset_mid();
`ifdef ARB_STRICT_PRIO_EN
        test_strict();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
